// File: rtl/tug_field_pkg.sv
// Shared constants, helpers and the move-decision encoding for the tug-of-war playfield.
package tug_pkg;

  localparam int N_DEFAULT               = 9;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

  typedef enum logic [1:0] {
    MV_HOLD   = 2'd0,
    MV_LEFT   = 2'd1,
    MV_RIGHT  = 2'd2,
    MV_CENTER = 2'd3
  } move_t;

  function automatic int center(input int n);
    return (n - 1) / 2;
  endfunction

  // Width of the position register for an n-LED row.
  function automatic int pos_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tug_field_key_conditioner.sv
// Per-key synchronizer, optional debounce filter (TUG_FIELD_DEBOUNCE_EN) and rising-edge pulse.
module key_conditioner
  import tug_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic key,
  output logic pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic filt_s;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("key_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end

  // Synchronizer and previous-level next state; pulse is the filtered rising edge.
  always_comb begin
    sync1_d = key;
    sync2_d = sync1_q;
    prev_d  = filt_s;
    pulse   = filt_s & ~prev_q;
  end

  // Synchronizer and edge-detect flops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

`ifdef TUG_FIELD_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Flip the filtered level on the Nth consecutive differing sample.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
    filt_s = filt_q;
  end

  // Debounce filter state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  // Without the filter the synchronized level is used directly.
  always_comb begin
    filt_s = sync2_q;
  end
`endif

endmodule

// File: rtl/tug_field.sv
// Tug-of-war playfield: conditions both keys and walks a one-hot light across N LEDs.
// Optional key debounce is enabled by defining TUG_FIELD_DEBOUNCE_EN.
module tug_field
  import tug_pkg::*;
#(
  parameter int N               = N_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         key_l,
  input  logic         key_r,
  input  logic         freset,
  output logic [N-1:0] leds,
  output logic         press_l,
  output logic         press_r,
  output logic         edge_l,
  output logic         edge_r
);

  localparam int PW = pos_width(N);
  localparam logic [PW-1:0] CENTER_POS = PW'(center(N));
  localparam logic [PW-1:0] MAX_POS    = PW'(N - 1);

  if ((N < 3) || ((N % 2) == 0)) begin : g_bad_n
    $error("tug_field: N must be odd and >= 3");
  end

  logic [PW-1:0] pos_q, pos_d;
  move_t         move_s;

  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_l (
    .clock (clock),
    .reset (reset),
    .key   (key_l),
    .pulse (press_l)
  );

  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_r (
    .clock (clock),
    .reset (reset),
    .key   (key_r),
    .pulse (press_r)
  );

  // Move arbitration: round reset wins, a tie cancels, edges saturate.
  always_comb begin
    move_s = MV_HOLD;
    if (freset) begin
      move_s = MV_CENTER;
    end else if (press_l && press_r) begin
      move_s = MV_HOLD;
    end else if (press_l && (pos_q < MAX_POS)) begin
      move_s = MV_LEFT;
    end else if (press_r && (pos_q > '0)) begin
      move_s = MV_RIGHT;
    end else begin
      move_s = MV_HOLD;
    end

    case (move_s)
      MV_CENTER: pos_d = CENTER_POS;
      MV_LEFT:   pos_d = pos_q + PW'(1);
      MV_RIGHT:  pos_d = pos_q - PW'(1);
      MV_HOLD:   pos_d = pos_q;
      default:   pos_d = CENTER_POS;
    endcase
  end

  // Light position register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pos_q <= CENTER_POS;
    end else begin
      pos_q <= pos_d;
    end
  end

  // One-hot decode of the position; edge flags feed the score counters.
  always_comb begin
    leds = '0;
    for (int i = 0; i < N; i++) begin
      leds[i] = (pos_q == PW'(i));
    end
    edge_l = leds[N-1];
    edge_r = leds[0];
  end

endmodule

// File: tb/tb_tug_field.sv
// Directed table-driven bench for tug_field (N=9); debounce checks when TUG_FIELD_DEBOUNCE_EN is set.
module tb_tug_field;

  localparam int N = 9;

  logic         clock;
  logic         reset;
  logic         key_l;
  logic         key_r;
  logic         freset;
  logic [N-1:0] leds;
  logic         press_l;
  logic         press_r;
  logic         edge_l;
  logic         edge_r;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         kl;
    logic         kr;
    logic         fr;
    logic         pl;
    logic         pr;
    logic [N-1:0] leds;
  } vec_t;

  vec_t vecs[$];

  tug_field #(.N(N), .DEBOUNCE_CYCLES(16)) dut (
    .clock   (clock),
    .reset   (reset),
    .key_l   (key_l),
    .key_r   (key_r),
    .freset  (freset),
    .leds    (leds),
    .press_l (press_l),
    .press_r (press_r),
    .edge_l  (edge_l),
    .edge_r  (edge_r)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic void add(input logic kl, input logic kr, input logic fr,
                              input logic pl, input logic pr, input logic [N-1:0] l);
    vec_t v;
    v.kl = kl; v.kr = kr; v.fr = fr; v.pl = pl; v.pr = pr; v.leds = l;
    vecs.push_back(v);
  endfunction

  // One short tap of a key: rise, pulse, settle at the new position.
  function automatic void tap(input logic left, input logic [N-1:0] old_l, input logic [N-1:0] new_l);
    add(left, ~left, 1'b0, 1'b0, 1'b0, old_l);
    add(1'b0, 1'b0, 1'b0, left, ~left, old_l);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, new_l);
  endfunction

  task automatic check_outs(input string tag, input logic pl, input logic pr, input logic [N-1:0] l);
    logic [N-1:0] lv;
    lv = l;
    check({tag, ".leds"}, 32'(leds), 32'(l));
    check({tag, ".press"}, {30'd0, press_l, press_r}, {30'd0, pl, pr});
    check({tag, ".edge"}, {30'd0, edge_l, edge_r}, {30'd0, lv[N-1], lv[0]});
  endtask

  task automatic count_pulse(input int budget, output int first, output int cnt);
    first = 0;
    cnt   = 0;
    for (int k = 1; k <= budget; k++) begin
      step();
      if (press_l) begin
        if (first == 0) first = k;
        cnt++;
      end
    end
  endtask

  initial begin
    int first;
    int cnt;

    reset  = 1'b0;
    key_l  = 1'b0;
    key_r  = 1'b0;
    freset = 1'b0;
    repeat (3) @(posedge clock);
    #3;
    check_outs("in_reset", 1'b0, 1'b0, 9'b000010000);
    reset = 1'b1;
    step();
    step();
    check_outs("after_reset", 1'b0, 1'b0, 9'b000010000);

`ifndef TUG_FIELD_DEBOUNCE_EN
    // Held left key: one pulse, one move.
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'b000010000);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'b000010000);
    for (int i = 0; i < 8; i++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'b000100000);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b000100000);
    // Walk to left edge, then saturate.
    tap(1'b1, 9'b000100000, 9'b001000000);
    tap(1'b1, 9'b001000000, 9'b010000000);
    tap(1'b1, 9'b010000000, 9'b100000000);
    tap(1'b1, 9'b100000000, 9'b100000000);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'b000010000);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b000010000);
    // Tie.
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'b000010000);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'b000010000);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b000010000);
    // Right to pos 2, then freset together with press_r.
    tap(1'b0, 9'b000010000, 9'b000001000);
    tap(1'b0, 9'b000001000, 9'b000000100);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'b000000100);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'b000000100);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'b000010000);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b000010000);
    // Walk to right edge and saturate.
    tap(1'b0, 9'b000010000, 9'b000001000);
    tap(1'b0, 9'b000001000, 9'b000000100);
    tap(1'b0, 9'b000000100, 9'b000000010);
    tap(1'b0, 9'b000000010, 9'b000000001);
    tap(1'b0, 9'b000000001, 9'b000000001);
    // Held freset swallows a left press.
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'b000010000);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'b000010000);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'b000010000);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b000010000);

    for (int i = 0; i < vecs.size(); i++) begin
      key_l  = vecs[i].kl;
      key_r  = vecs[i].kr;
      freset = vecs[i].fr;
      step();
      check_outs($sformatf("row%0d", i), vecs[i].pl, vecs[i].pr, vecs[i].leds);
    end

    // Reset asserted while the pulse is high, key still held at release.
    key_l = 1'b1;
    step();
    step();
    check("midreset.pre_pulse", {31'd0, press_l}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check_outs("midreset.now", 1'b0, 1'b0, 9'b000010000);
    #2 reset = 1'b1;
    step();
    check_outs("midreset.e1", 1'b0, 1'b0, 9'b000010000);
    step();
    check_outs("midreset.e2", 1'b1, 1'b0, 9'b000010000);
    step();
    check_outs("midreset.e3", 1'b0, 1'b0, 9'b000100000);
    key_l = 1'b0;
`else
    // Short glitch must be filtered out.
    key_l = 1'b1;
    count_pulse(5, first, cnt);
    key_l = 1'b0;
    begin
      int f2;
      int c2;
      count_pulse(30, f2, c2);
      check("glitch.pulses", 32'(cnt + c2), 32'd0);
    end
    check("glitch.leds", 32'(leds), 32'(9'b000010000));
    // 20-cycle hold: one pulse at the 18th edge.
    key_l = 1'b1;
    count_pulse(20, first, cnt);
    check("hold.first", 32'(first), 32'd18);
    check("hold.count", 32'(cnt), 32'd1);
    key_l = 1'b0;
    count_pulse(20, first, cnt);
    check("release.count", 32'(cnt), 32'd0);
    check("hold.leds", 32'(leds), 32'(9'b000100000));
    // Reset mid-hold.
    key_l = 1'b1;
    repeat (10) step();
    #2 reset = 1'b0;
    #1;
    check_outs("dbreset.now", 1'b0, 1'b0, 9'b000010000);
    #2 reset = 1'b1;
    count_pulse(25, first, cnt);
    check("dbreset.first", 32'(first), 32'd18);
    check("dbreset.count", 32'(cnt), 32'd1);
    key_l = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tug_field.md
# tug_field

Playfield stage of the tug-of-war game, directly upstream of the per-player score counters. It conditions the two player keys into single-cycle press pulses and moves one lit LED across an odd-length LED row. It drives each counter's `led` (edge LED lit) and `dir` (that player's press) inputs. It recentres the light when a counter returns its `freset` round-reset pulse.

## Interface
- `N`, default 9: LED count; odd, ≥3; elaboration error otherwise.
- `DEBOUNCE_CYCLES`, default 16: stable-sample count; used only when debounce is compiled in; ≥1.
- `clock`  in  1: sole clock, all state on rising edge.
- `reset`  in  1: asynchronous, active-low; asserting it clears all state immediately; deassertion is synchronous to `clock` at the upper level.
- `key_l`  in  1: left player key, active-high, asynchronous to `clock`.
- `key_r`  in  1: right player key, active-high, asynchronous.
- `freset`  in  1: round reset from either counter (OR'd at upper level); synchronous, active-high.
- `leds`  out  N: one-hot playfield; `leds[N-1]` leftmost, `leds[0]` rightmost.
- `press_l`  out  1: one-cycle pulse per accepted left press (feeds left counter `dir`).
- `press_r`  out  1: one-cycle pulse per accepted right press (feeds right counter `dir`).
- `edge_l`  out  1: `leds[N-1]` (feeds left counter `led`).
- `edge_r`  out  1: `leds[0]` (feeds right counter `led`).

## Operation
- Position register `pos`, range 0..N-1, width `$clog2(N)`. `leds` = one-hot of `pos`. CENTER = (N-1)/2.
- Reset values: `pos` = CENTER (`leds` = 9'b000010000 for N=9), `press_l`/`press_r` = 0, `edge_l`/`edge_r` = 0, synchronizer and edge-detect flops = 0.
- Key conditioning, per key: 2-flop synchronizer, then an optional debounce filter, then a rising-edge detector. Holding a key produces exactly one pulse. There is no auto-repeat.
- Move rules, evaluated at each rising edge in priority order:
  1. `freset`=1: `pos` ← CENTER; presses in the same cycle are discarded.
  2. `press_l` and `press_r` both 1: no move (tie cancels).
  3. `press_l`=1 and `pos`<N-1: `pos` ← `pos`+1.
  4. `press_r`=1 and `pos`>0: `pos` ← `pos`-1.
  5. Otherwise hold.
- Saturation at the edges:
  - `press_l` with `pos`=N-1 leaves `pos` unchanged. This is the scoring event: the downstream counter sees `edge_l`&`press_l`.
  - `press_r` with `pos`=0 behaves the same on the right edge.
- A pulse is still emitted during a tie or `freset` cycle. Downstream counters gate it with their own `led` input.
- No wrap-around; `pos` is never outside 0..N-1.

## Timing
- Key high first sampled at edge t: synchronizer output is high after edge t+1.
- `press_*` is high for exactly the cycle between edges t+1 and t+2 (combinational from synchronizer stage 2 and previous-level flop). `pos` updates at edge t+2.
- With debounce compiled in, add DEBOUNCE_CYCLES cycles of latency.
- `freset` asserted in a cycle: `leds` shows CENTER after the next edge. `freset` held for several cycles keeps `pos` at CENTER.
- A key release followed by a re-press needs a low sample (post-filter) between presses to create a new pulse.
- `reset` asserted mid-press: the pulse is aborted and outputs go to reset values immediately. A key still held at deassertion generates one pulse, 2 cycles after the first sampling edge.

## Configuration
- `TUG_FIELD_DEBOUNCE_EN` defined: each key filter has a counter that changes the filtered level only after DEBOUNCE_CYCLES consecutive identical synchronized samples. A glitch shorter than that produces no pulse.
- Not defined: the filtered level equals synchronizer stage 2 and the counter logic is absent; latency is 2 edges.

## Structure
- Package `tug_pkg`: default `N`, `CENTER` function/constant, `pos_t` width helper, default `DEBOUNCE_CYCLES`.
- Sub-module `key_conditioner` contains the synchronizer, the debounce filter guarded by the macro, and the edge detector with a `pulse` output. It is instantiated twice, for left and right.

## Test plan
- Reset low, then high, with keys idle → `leds`=9'b000010000; `press_*`=0; `edge_*`=0.
- Single left press held 10 cycles → exactly one `press_l` pulse, 2 edges after the first sample; `leds`=9'b000100000.
- 4 left presses from centre → `leds`=9'b100000000, `edge_l`=1. A 5th press → `press_l` pulses and `leds` stays 9'b100000000. Then `freset` for one cycle → `leds`=9'b000010000.
- Both keys rising on the same edge → both pulses asserted, `leds` unchanged.
- `freset` asserted in the same cycle as `press_r` from `pos`=2 → `pos`=CENTER, no move.
- With `TUG_FIELD_DEBOUNCE_EN`, DEBOUNCE_CYCLES=16: a 5-cycle key glitch → no pulse. A 20-cycle hold → one pulse, 18 edges after the first sample. `reset` asserted mid-hold → outputs return to reset values immediately.
